// File: rtl/fg_ctrl_pkg.sv
// Shared types and constants for the function-generator front-end controller.
// Holds the state encoding, command codes and saturating gear helpers.
package fg_ctrl_pkg;

    localparam int WAVE_W = 2;
    localparam int GEAR_W = 2;

    localparam logic [GEAR_W-1:0] GEAR_MAX = 2'd3;
    localparam logic [GEAR_W-1:0] GEAR_MIN = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_RUN    = 2'd2,
        ST_SWEEP  = 2'd3
    } fg_state_e;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_STOP    = 3'd1,
        CMD_START   = 3'd2,
        CMD_SWEEP   = 3'd3,
        CMD_WAVE    = 3'd4,
        CMD_GEAR_UP = 3'd5,
        CMD_GEAR_DN = 3'd6
    } fg_cmd_e;

    function automatic logic [GEAR_W-1:0] gear_inc(input logic [GEAR_W-1:0] g);
        if (g == GEAR_MAX) begin
            return g;
        end else begin
            return g + 2'd1;
        end
    endfunction

    function automatic logic [GEAR_W-1:0] gear_dec(input logic [GEAR_W-1:0] g);
        if (g == GEAR_MIN) begin
            return g;
        end else begin
            return g - 2'd1;
        end
    endfunction

endpackage

// File: rtl/fg_cycle_timer.sv
// Cycle counter shared by the restart and sweep phases; clear dominates enable
// and the count parks at the terminal value instead of wrapping.
module fg_cycle_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term_val,
    output logic             at_term
);

    logic [CNT_W-1:0] count_r;

    // Counter register with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && !at_term) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign at_term = (count_r == term_val);

endmodule

// File: rtl/fg_sweep_controller.sv
// Function-generator front end: command decode, clean restart on waveform change
// and automatic gear sweep. Build option SWEEP_LOOP_EN makes the sweep repeat until stopped.
module fg_sweep_controller
    import fg_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES  = 50_000_000,
    parameter int RESYNC_CYCLES = 400,
    parameter int CNT_W         = 26
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              wave_next,
    input  logic              gear_up,
    input  logic              gear_down,
    input  logic              sweep_start,
    output logic [WAVE_W-1:0] wave_select,
    output logic [GEAR_W-1:0] gears,
    output logic              gen_rstn,
    output logic [1:0]        state,
    output logic              sweep_done
);

    localparam logic [CNT_W-1:0] DWELL_TERM  = CNT_W'(DWELL_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] RESYNC_TERM = CNT_W'(RESYNC_CYCLES - 32'sd1);

    fg_state_e         state_r;
    fg_state_e         state_nxt_s;
    logic [WAVE_W-1:0] wave_r;
    logic [WAVE_W-1:0] wave_nxt_s;
    logic [GEAR_W-1:0] gears_r;
    logic [GEAR_W-1:0] gears_nxt_s;
    logic [GEAR_W-1:0] gear_saved_r;
    logic [GEAR_W-1:0] gear_saved_nxt_s;
    logic              gen_rstn_r;
    logic              sweep_done_r;
    logic              done_nxt_s;
    fg_cmd_e           cmd_s;
    logic              tmr_clr_s;
    logic              tmr_en_s;
    logic              tmr_at_term_s;
    logic [CNT_W-1:0]  tmr_term_s;

    fg_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk_50MHz),
        .rst      (rst),
        .clr      (tmr_clr_s),
        .en       (tmr_en_s),
        .term_val (tmr_term_s),
        .at_term  (tmr_at_term_s)
    );

    // Pick the single highest-priority command that is meaningful in the current state.
    always_comb begin
        cmd_s = CMD_NONE;
        if (stop) begin
            cmd_s = CMD_STOP;
        end else if (start && (state_r == ST_IDLE)) begin
            cmd_s = CMD_START;
        end else if (sweep_start && (state_r == ST_RUN)) begin
            cmd_s = CMD_SWEEP;
        end else if (wave_next && (state_r != ST_SWEEP)) begin
            cmd_s = CMD_WAVE;
        end else if (gear_up && (state_r != ST_SWEEP)) begin
            cmd_s = CMD_GEAR_UP;
        end else if (gear_down && (state_r != ST_SWEEP)) begin
            cmd_s = CMD_GEAR_DN;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Next-state and next-output logic; timer events are suppressed by stop or a restart.
    always_comb begin
        state_nxt_s      = state_r;
        wave_nxt_s       = wave_r;
        gears_nxt_s      = gears_r;
        gear_saved_nxt_s = gear_saved_r;
        done_nxt_s       = 1'b0;
        tmr_clr_s        = 1'b0;
        tmr_en_s         = (state_r == ST_RESYNC) || (state_r == ST_SWEEP);
        tmr_term_s       = (state_r == ST_SWEEP) ? DWELL_TERM : RESYNC_TERM;

        case (cmd_s)
            CMD_STOP: begin
                state_nxt_s = ST_IDLE;
                tmr_clr_s   = 1'b1;
                if (state_r == ST_SWEEP) begin
                    gears_nxt_s = gear_saved_r;
                end else begin
                    gears_nxt_s = gears_r;
                end
            end
            CMD_START: begin
                state_nxt_s = ST_RESYNC;
                tmr_clr_s   = 1'b1;
            end
            CMD_SWEEP: begin
                gear_saved_nxt_s = gears_r;
                gears_nxt_s      = GEAR_MIN;
                state_nxt_s      = ST_SWEEP;
                tmr_clr_s        = 1'b1;
            end
            CMD_WAVE: begin
                wave_nxt_s = wave_r + 2'd1;
                if (state_r == ST_IDLE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESYNC;
                    tmr_clr_s   = 1'b1;
                end
            end
            CMD_GEAR_UP: gears_nxt_s = gear_inc(gears_r);
            CMD_GEAR_DN: gears_nxt_s = gear_dec(gears_r);
            CMD_NONE:    gears_nxt_s = gears_r;
            default:     gears_nxt_s = gears_r;
        endcase

        if ((cmd_s != CMD_STOP) && (cmd_s != CMD_WAVE) && tmr_en_s && tmr_at_term_s) begin
            tmr_clr_s = 1'b1;
            if (state_r == ST_RESYNC) begin
                state_nxt_s = ST_RUN;
            end else if (gears_r != GEAR_MAX) begin
                gears_nxt_s = gear_inc(gears_r);
            end else begin
                done_nxt_s = 1'b1;
`ifdef SWEEP_LOOP_EN
                gears_nxt_s = GEAR_MIN;
`else
                gears_nxt_s = gear_saved_r;
                state_nxt_s = ST_RUN;
`endif
            end
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wave_r       <= {WAVE_W{1'b0}};
            gears_r      <= {GEAR_W{1'b0}};
            gear_saved_r <= {GEAR_W{1'b0}};
            gen_rstn_r   <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wave_r       <= wave_nxt_s;
            gears_r      <= gears_nxt_s;
            gear_saved_r <= gear_saved_nxt_s;
            gen_rstn_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_SWEEP);
            sweep_done_r <= done_nxt_s;
        end
    end

    assign wave_select = wave_r;
    assign gears       = gears_r;
    assign gen_rstn    = gen_rstn_r;
    assign state       = state_r;
    assign sweep_done  = sweep_done_r;

endmodule

// File: tb/tb_fg_sweep_controller.sv
// Self-checking bench for fg_sweep_controller: constant vector table, directed
// corner sequences and randomized commands against a cycle-count reference model.
module tb_fg_sweep_controller;

    localparam int DWELL  = 10;
    localparam int RESYNC = 4;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_RST   = 7'b1000000;
    localparam logic [6:0] C_STOP  = 7'b0100000;
    localparam logic [6:0] C_START = 7'b0010000;
    localparam logic [6:0] C_SWEEP = 7'b0001000;
    localparam logic [6:0] C_WAVE  = 7'b0000100;
    localparam logic [6:0] C_UP    = 7'b0000010;
    localparam logic [6:0] C_DN    = 7'b0000001;

    logic       clk_50MHz = 1'b0;
    logic       rst = 1'b0, start = 1'b0, stop = 1'b0, wave_next = 1'b0;
    logic       gear_up = 1'b0, gear_down = 1'b0, sweep_start = 1'b0;
    logic [1:0] wave_select, gears, state;
    logic       gen_rstn, sweep_done;

    int checks = 0;
    int errors = 0;

    // reference model: phase length kept as "cycles remaining"
    int m_state = 0, m_wave = 0, m_gear = 0, m_saved = 0, m_left = 0;
    int m_done = 0;

    typedef struct {
        logic [6:0] cmd;
        int         st;
        int         wv;
        int         gr;
        int         rn;
        int         dn;
    } vec_t;

    vec_t tbl[22];

    always #10 clk_50MHz = ~clk_50MHz;

    fg_sweep_controller #(
        .DWELL_CYCLES  (DWELL),
        .RESYNC_CYCLES (RESYNC),
        .CNT_W         (8)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .wave_next   (wave_next),
        .gear_up     (gear_up),
        .gear_down   (gear_down),
        .sweep_start (sweep_start),
        .wave_select (wave_select),
        .gears       (gears),
        .gen_rstn    (gen_rstn),
        .state       (state),
        .sweep_done  (sweep_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void gear_cmd(input bit up, input bit dn);
        if (up) m_gear = (m_gear < 3) ? m_gear + 1 : 3;
        else if (dn) m_gear = (m_gear > 0) ? m_gear - 1 : 0;
    endfunction

    function automatic void model_step(input logic [6:0] c);
        bit r  = c[6];
        bit sp = c[5];
        bit st = c[4];
        bit sw = c[3];
        bit wv = c[2];
        bit up = c[1];
        bit dn = c[0];
        m_done = 0;
        if (r) begin
            m_state = 0; m_wave = 0; m_gear = 0; m_saved = 0; m_left = 0;
        end else if (sp) begin
            if (m_state == 3) m_gear = m_saved;
            m_state = 0;
        end else if (m_state == 0) begin
            if (st) begin
                m_state = 1; m_left = RESYNC;
            end else if (wv) m_wave = (m_wave + 1) % 4;
            else gear_cmd(up, dn);
        end else if (m_state == 1) begin
            if (wv) begin
                m_wave = (m_wave + 1) % 4; m_left = RESYNC;
            end else begin
                gear_cmd(up, dn);
                m_left--;
                if (m_left == 0) m_state = 2;
            end
        end else if (m_state == 2) begin
            if (sw) begin
                m_saved = m_gear; m_gear = 0; m_state = 3; m_left = DWELL;
            end else if (wv) begin
                m_wave = (m_wave + 1) % 4; m_state = 1; m_left = RESYNC;
            end else gear_cmd(up, dn);
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_left = DWELL;
                if (m_gear < 3) m_gear++;
                else begin
                    m_done = 1;
`ifdef SWEEP_LOOP_EN
                    m_gear = 0;
`else
                    m_gear = m_saved; m_state = 2;
`endif
                end
            end
        end
    endfunction

    task automatic apply(input logic [6:0] c);
        {rst, stop, start, sweep_start, wave_next, gear_up, gear_down} = c;
        @(posedge clk_50MHz);
        model_step(c);
        #1;
    endtask

    task automatic cmp_model();
        chk("state", int'(state), m_state);
        chk("wave_select", int'(wave_select), m_wave);
        chk("gears", int'(gears), m_gear);
        chk("gen_rstn", int'(gen_rstn), (m_state >= 2) ? 1 : 0);
        chk("sweep_done", int'(sweep_done), m_done);
    endtask

    task automatic go_run();
        int n = 0;
        apply(C_START);
        cmp_model();
        while (state != 2'd2 && n < 20) begin
            apply(C_NONE);
            cmp_model();
            n++;
        end
        chk("reach_run", int'(state), 2);
    endtask

    initial begin
        int n;
        int done_cnt;
        int done_first;
        int done_second;
        int w_before;
        logic [6:0] c;

        tbl[0]  = '{C_RST,          0, 0, 0, 0, 0};
        tbl[1]  = '{C_RST,          0, 0, 0, 0, 0};
        tbl[2]  = '{C_NONE,         0, 0, 0, 0, 0};
        tbl[3]  = '{C_UP,           0, 0, 1, 0, 0};
        tbl[4]  = '{C_WAVE,         0, 1, 1, 0, 0};
        tbl[5]  = '{C_DN,           0, 1, 0, 0, 0};
        tbl[6]  = '{C_SWEEP,        0, 1, 0, 0, 0};
        tbl[7]  = '{C_START,        1, 1, 0, 0, 0};
        tbl[8]  = '{C_NONE,         1, 1, 0, 0, 0};
        tbl[9]  = '{C_UP,           1, 1, 1, 0, 0};
        tbl[10] = '{C_NONE,         1, 1, 1, 0, 0};
        tbl[11] = '{C_NONE,         2, 1, 1, 1, 0};
        tbl[12] = '{C_UP,           2, 1, 2, 1, 0};
        tbl[13] = '{C_UP | C_DN,    2, 1, 3, 1, 0};
        tbl[14] = '{C_UP,           2, 1, 3, 1, 0};
        tbl[15] = '{C_START | C_DN, 2, 1, 2, 1, 0};
        tbl[16] = '{C_STOP | C_WAVE, 0, 1, 2, 0, 0};
        tbl[17] = '{C_START | C_WAVE, 1, 1, 2, 0, 0};
        tbl[18] = '{C_STOP,         0, 1, 2, 0, 0};
        tbl[19] = '{C_WAVE | C_UP,  0, 2, 2, 0, 0};
        tbl[20] = '{C_START,        1, 2, 2, 0, 0};
        tbl[21] = '{C_RST,          0, 0, 0, 0, 0};

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].cmd);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("tbl%0d_wave", i), int'(wave_select), tbl[i].wv);
            chk($sformatf("tbl%0d_gears", i), int'(gears), tbl[i].gr);
            chk($sformatf("tbl%0d_rstn", i), int'(gen_rstn), tbl[i].rn);
            chk($sformatf("tbl%0d_done", i), int'(sweep_done), tbl[i].dn);
        end

        // start from IDLE: RESYNC must last exactly RESYNC cycles
        apply(C_START);
        cmp_model();
        n = 0;
        while (state == 2'd1 && n < 20) begin
            apply(C_NONE);
            cmp_model();
            n++;
        end
        chk("resync_len", n, RESYNC);

        for (int k = 0; k < 4; k++) begin
            apply(C_WAVE);
            cmp_model();
            chk("wave_after_next", int'(wave_select), (k + 1) % 4);
            for (int j = 0; j < 9; j++) begin
                apply(C_NONE);
                cmp_model();
            end
        end
        for (int k = 0; k < 5; k++) begin
            apply(C_UP);
            cmp_model();
        end
        chk("gear_sat_hi", int'(gears), 3);
        for (int k = 0; k < 4; k++) begin
            apply(C_DN);
            cmp_model();
        end
        chk("gear_sat_lo", int'(gears), 0);

        // full sweep from gears=2
        apply(C_UP);
        apply(C_UP);
        cmp_model();
        apply(C_SWEEP);
        cmp_model();
        done_cnt = 0; done_first = -1; done_second = -1;
        for (int i = 1; i <= 85; i++) begin
            apply(C_NONE);
            cmp_model();
            if (sweep_done) begin
                done_cnt++;
                if (done_first < 0) done_first = i;
                else if (done_second < 0) done_second = i;
            end
        end
        chk("sweep_done_cycle", done_first, 40);
`ifdef SWEEP_LOOP_EN
        chk("sweep_done_count", done_cnt, 2);
        chk("sweep_done_cycle2", done_second, 80);
        chk("loop_gear_85", int'(gears), 0);
`else
        chk("sweep_done_count", done_cnt, 1);
        chk("sweep_return_state", int'(state), 2);
`endif
        apply(C_STOP);
        cmp_model();
        chk("stop_restore", int'(gears), 2);

        // abort a sweep at cycle 25 with gear_saved=1
        go_run();
        apply(C_DN);
        cmp_model();
        w_before = int'(wave_select);
        apply(C_SWEEP);
        cmp_model();
        for (int i = 1; i < 25; i++) begin
            apply((i % 3 == 0) ? C_UP : ((i % 5 == 0) ? C_WAVE : C_NONE));
            cmp_model();
        end
        apply(C_STOP);
        cmp_model();
        chk("abort_state", int'(state), 0);
        chk("abort_gears", int'(gears), 1);
        chk("abort_done", int'(sweep_done), 0);
        chk("abort_wave", int'(wave_select), w_before);

        // wave_next at count 3 of RESYNC restarts the full low period
        apply(C_START);
        cmp_model();
        for (int i = 0; i < 3; i++) begin
            apply(C_NONE);
            cmp_model();
        end
        apply(C_WAVE);
        cmp_model();
        n = 0;
        while (gen_rstn == 1'b0 && n < 20) begin
            n++;
            apply(C_NONE);
            cmp_model();
        end
        chk("resync_restart_len", n, RESYNC);

        // randomized commands against the model
        for (int i = 0; i < 4000; i++) begin
            c = C_NONE;
            if ($urandom_range(499, 0) == 0) c = c | C_RST;
            if ($urandom_range(59, 0) == 0) c = c | C_STOP;
            if ($urandom_range(9, 0) == 0) c = c | C_START;
            if ($urandom_range(19, 0) == 0) c = c | C_SWEEP;
            if ($urandom_range(14, 0) == 0) c = c | C_WAVE;
            if ($urandom_range(7, 0) == 0) c = c | C_UP;
            if ($urandom_range(7, 0) == 0) c = c | C_DN;
            apply(c);
            cmp_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fg_sweep_controller.md
Name: fg_sweep_controller

Overview:
- Front-end controller for the function generator.
- Turns single-cycle user command pulses into the generator's configuration: wave_select, gears and an active-low run/reset line.
- Sequences a clean restart whenever the waveform table changes.
- Runs an automatic frequency sweep that steps through all four gears with a programmable dwell.
- Sits between the key/command logic and the generator top level; everything runs in the 50 MHz domain.

Parameters:
- DWELL_CYCLES, 50_000_000, clk_50MHz cycles spent on each gear during a sweep (1 s); must be ≥2.
- RESYNC_CYCLES, 400, cycles gen_rstn is held low on (re)start; covers ≥2 edges of the generator's /200 clock; must be ≥1.
- CNT_W, 26, width of the shared cycle counter; must satisfy 2^CNT_W > max(DWELL_CYCLES, RESYNC_CYCLES).

Ports:
- clk_50MHz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: leave IDLE and start output.
- stop  in  1  pulse: stop output, return to IDLE.
- wave_next  in  1  pulse: advance waveform, 3 wraps to 0.
- gear_up  in  1  pulse: gear +1, saturates at 3.
- gear_down  in  1  pulse: gear −1, saturates at 0.
- sweep_start  in  1  pulse: begin automatic gear sweep.
- wave_select  out  2  to generator wave_select.
- gears  out  2  to generator gears.
- gen_rstn  out  1  to generator rstn; 0 stops and re-initialises phase.
- state  out  2  IDLE=0, RESYNC=1, RUN=2, SWEEP=3.
- sweep_done  out  1  one-cycle pulse at the end of each sweep pass.

Behaviour:
- All outputs are registered. A command sampled on cycle N is visible on cycle N+1.
- Reset values: state=IDLE, wave_select=0, gears=0, gen_rstn=0, sweep_done=0, internal gear_saved=0, counter=0.
- Command priority when several pulses arrive together: stop > start > sweep_start > wave_next > gear_up > gear_down. Only the highest-priority command valid in the current state acts; the rest are dropped.
- gen_rstn = 1 only in RUN and SWEEP.
- IDLE:
  - start → RESYNC with counter=0.
  - wave_next and gear_up/gear_down update the registers; the state does not change.
  - sweep_start is ignored.
- RESYNC:
  - gen_rstn=0 for exactly RESYNC_CYCLES consecutive cycles, then RUN.
  - wave_next applies the change and restarts the count from 0.
  - gear_up/gear_down apply without restarting the count.
  - start and sweep_start are ignored.
- RUN:
  - wave_next → wave_select advances and the state goes to RESYNC. A waveform change always restarts the phase accumulator.
  - gear_up/gear_down change gears without resync; the frequency step is phase-continuous.
  - sweep_start → gear_saved<=gears, gears<=0, counter<=0, state SWEEP.
- SWEEP:
  - Counter increments each cycle.
  - When counter==DWELL_CYCLES−1 and gears<3: gears+1 and counter<=0.
  - When counter==DWELL_CYCLES−1 and gears==3: sweep_done=1 for one cycle, gears<=gear_saved, state RUN.
  - wave_next, gear_up, gear_down, start and sweep_start are ignored.
- stop in any state: IDLE on the next cycle, gen_rstn=0, counter cleared, wave_select retained. gears is restored to gear_saved if stop arrives in SWEEP, otherwise retained. No sweep_done pulse on abort.
- stop has priority over a coincident counter terminal event: no gear step and no sweep_done.
- rst mid-operation returns every register to its reset value on the next edge.
- Counter arithmetic is unsigned, CNT_W bits, never wraps. The terminal compares are equality against the parameter minus 1.

Optional Feature:
- Macro: SWEEP_LOOP_EN.
- Defined: at the end of gear 3 the sweep wraps to gear 0 and continues. sweep_done pulses once per completed pass. SWEEP exits only via stop, which restores gear_saved.
- Undefined: single pass as described above, then return to RUN with gear_saved.

Decomposition:
- Shared package fg_ctrl_pkg holds:
  - state encoding constants ST_IDLE/ST_RESYNC/ST_RUN/ST_SWEEP;
  - GEAR_MAX=2'd3;
  - WAVE_W=2 and GEAR_W=2.
- One sub-module, fg_cycle_timer: a CNT_W counter with clear, enable and a terminal-count compare input.
  - Shared by the RESYNC and SWEEP states, since they are mutually exclusive.
  - The FSM and command decode stay in the top module.

Test Plan (DWELL_CYCLES=10, RESYNC_CYCLES=4):
- rst high 2 cycles, then start pulse → state=1 and gen_rstn=0 for exactly 4 cycles, then state=2 and gen_rstn=1; wave_select=0, gears=0.
- In RUN, wave_next ×4 spaced 10 cycles apart → wave_select 1,2,3,0, each followed by a 4-cycle gen_rstn low; gear_up ×5 → gears saturates at 3 with gen_rstn constantly 1; gear_down ×4 → 0.
- RUN with gears=2, sweep_start → gears 0,1,2,3 each held 10 cycles; one sweep_done pulse on cycle 40; gears returns to 2, state=2.
- SWEEP with gear_saved=1, stop at cycle 25 → next cycle state=0, gen_rstn=0, gears=1, no sweep_done; gear_up and wave_next during the sweep had no effect.
- RUN: stop and wave_next in the same cycle → IDLE, wave_select unchanged. RESYNC: wave_next at count 3 → gen_rstn low for 4 more cycles.
- With SWEEP_LOOP_EN: sweep for 85 cycles → gears sequence 0..3,0..3,0, sweep_done at cycles 40 and 80; stop → gear_saved restored.
